car_light_ctrl: RTL and testbench

Light-request controller for the car simulation. It turns driver and vehicle state (power, turn stalks, hazard button, brake) into the stay_left/stay_right/twinkle_left/twinkle_right request lines that the LED driver consumes. It also generates blink_clk, the slow square wave that clocks the LED driver so that twinkle toggles at a visible rate. Position in the design: between the control-input logic and the LED driver.

---
 rtl/car_light_pkg.sv | 23 ++
 rtl/car_light_if.sv | 26 ++
 rtl/car_blink_div.sv | 37 +++
 rtl/car_light_ctrl.sv | 148 ++++++++++++++
 tb/tb_car_light_ctrl.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/car_light_pkg.sv
// Shared types and constants for the car light-request controller.
package car_light_pkg;

    typedef enum logic [2:0] {
        OFF,
        SELFTEST,
        IDLE,
        TURN_L,
        TURN_R
    } state_t;

    localparam int unsigned OUT_STAY_L = 0;
    localparam int unsigned OUT_STAY_R = 1;
    localparam int unsigned OUT_TW_L   = 2;
    localparam int unsigned OUT_TW_R   = 3;
    localparam int unsigned OUT_W      = 4;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/car_light_if.sv
// Control inputs and light-request outputs between the control logic and LED driver.
interface car_light_if;
    import car_light_pkg::*;

    logic power_on;
    logic turn_left;
    logic turn_right;
    logic hazard_btn;
    logic brake;
    logic stay_left;
    logic stay_right;
    logic twinkle_left;
    logic twinkle_right;
    logic blink_clk;

    modport master (
        output power_on, turn_left, turn_right, hazard_btn, brake,
        input  stay_left, stay_right, twinkle_left, twinkle_right, blink_clk
    );

    modport slave (
        input  power_on, turn_left, turn_right, hazard_btn, brake,
        output stay_left, stay_right, twinkle_left, twinkle_right, blink_clk
    );

endinterface

// File: rtl/car_blink_div.sv
// Free-running prescaler producing the slow blink_clk square wave.
module car_blink_div
    import car_light_pkg::*;
#(
    parameter int unsigned HALF_PERIOD = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    output logic blink_clk
);

    localparam int unsigned W = cnt_w(HALF_PERIOD);
    localparam logic [W-1:0] LAST = W'(HALF_PERIOD - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         blink_q, blink_d;
    logic         wrap;

    always_comb begin
        wrap    = (cnt_q == LAST);
        cnt_d   = wrap ? '0 : cnt_q + W'(1);
        blink_d = blink_q ^ wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

    assign blink_clk = blink_q;

endmodule

// File: rtl/car_light_ctrl.sv
// Light-request FSM: selftest, turn hold, hazard latch and registered output decode.
module car_light_ctrl
    import car_light_pkg::*;
#(
    parameter int unsigned HALF_PERIOD     = 25_000_000,
    parameter int unsigned SELFTEST_CYCLES = 100_000_000,
    parameter int unsigned HOLD_CYCLES     = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    car_light_if.slave  bus
);

    localparam int unsigned CMAX =
        (SELFTEST_CYCLES > HOLD_CYCLES) ? SELFTEST_CYCLES : HOLD_CYCLES;
    localparam int unsigned CW = cnt_w(CMAX);
    localparam logic [CW-1:0] ST_LAST   = CW'(SELFTEST_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             haz_q, haz_d;
    logic             hzb_q;
    logic [OUT_W-1:0] out_q, out_d;
    logic             hz_rise;
    logic             l_only, r_only;
    logic             blink;

    car_blink_div #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .blink_clk (blink)
    );

    assign hz_rise = bus.hazard_btn & ~hzb_q;
    assign l_only  = bus.turn_left & ~bus.turn_right;
    assign r_only  = bus.turn_right & ~bus.turn_left;

    // One counter serves both selftest and turn hold; the states never overlap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        haz_d   = haz_q;
        if (!bus.power_on) begin
            state_d = OFF;
            cnt_d   = '0;
            haz_d   = 1'b0;
        end else begin
            if (hz_rise) haz_d = ~haz_q;
            unique case (state_q)
                OFF: begin
                    state_d = SELFTEST;
                    cnt_d   = '0;
                end
                SELFTEST: begin
                    if (cnt_q == ST_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                IDLE: begin
                    cnt_d = '0;
                    if (l_only)      state_d = TURN_L;
                    else if (r_only) state_d = TURN_R;
                end
                TURN_L: begin
                    if (r_only) begin
                        state_d = TURN_R;
                        cnt_d   = '0;
                    end else if (bus.turn_left) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                TURN_R: begin
                    if (l_only) begin
                        state_d = TURN_L;
                        cnt_d   = '0;
                    end else if (bus.turn_right) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = OFF;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Decode from next-state so an input sampled at an edge shows right after it.
    always_comb begin
        out_d = '0;
        priority case (1'b1)
            (state_d == OFF): out_d = '0;
            (state_d == SELFTEST): begin
                out_d[OUT_STAY_L] = 1'b1;
                out_d[OUT_STAY_R] = 1'b1;
            end
            haz_d: begin
                out_d[OUT_TW_L] = 1'b1;
                out_d[OUT_TW_R] = 1'b1;
            end
            default: begin
                out_d[OUT_TW_L]   = (state_d == TURN_L);
                out_d[OUT_TW_R]   = (state_d == TURN_R);
                out_d[OUT_STAY_L] = (state_d != TURN_L) & bus.brake;
                out_d[OUT_STAY_R] = (state_d != TURN_R) & bus.brake;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= OFF;
            cnt_q   <= '0;
            haz_q   <= 1'b0;
            hzb_q   <= 1'b0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            haz_q   <= haz_d;
            hzb_q   <= bus.hazard_btn;
            out_q   <= out_d;
        end
    end

    assign bus.stay_left     = out_q[OUT_STAY_L];
    assign bus.stay_right    = out_q[OUT_STAY_R];
    assign bus.twinkle_left  = out_q[OUT_TW_L];
    assign bus.twinkle_right = out_q[OUT_TW_R];
    assign bus.blink_clk     = blink;

endmodule

// File: tb/tb_car_light_ctrl.sv
// Directed self-checking bench for car_light_ctrl (HALF_PERIOD=2, SELFTEST=4, HOLD=3).
module tb_car_light_ctrl;

    logic clk;
    logic rst;
    int   vecs;
    int   errs;
    int   ecnt;
    logic exp_blink;

    car_light_if bus();

    car_light_ctrl #(
        .HALF_PERIOD     (2),
        .SELFTEST_CYCLES (4),
        .HOLD_CYCLES     (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {twinkle_right, twinkle_left, stay_right, stay_left}
    logic [3:0] outs;
    assign outs = {bus.twinkle_right, bus.twinkle_left,
                   bus.stay_right, bus.stay_left};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns past it; ecnt counts edges since reset.
    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.power_on = 1'b0;
        bus.turn_left = 1'b0;
        bus.turn_right = 1'b0;
        bus.hazard_btn = 1'b0;
        bus.brake = 1'b0;
        #1;
        vecs++;
        if (outs !== 4'b0000) begin
            errs++;
            $display("FAIL reset_outs: got %b want 0000", outs);
        end
        vecs++;
        if (bus.blink_clk !== 1'b0) begin
            errs++;
            $display("FAIL reset_blink: got %b want 0", bus.blink_clk);
        end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        ecnt = 0;
        tick();
        vecs++;
        if (outs !== 4'b0000) begin
            errs++;
            $display("FAIL off_idle: got %b want 0000", outs);
        end
    endtask

    task automatic test_selftest();
        bus.power_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b0011) begin
                errs++;
                $display("FAIL selftest_%0d: got %b want 0011", i, outs);
            end
            exp_blink = ((ecnt / 2) % 2) == 1;
            vecs++;
            if (bus.blink_clk !== exp_blink) begin
                errs++;
                $display("FAIL blink_st_%0d: got %b want %b", i, bus.blink_clk, exp_blink);
            end
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b0000) begin
                errs++;
                $display("FAIL post_selftest_%0d: got %b want 0000", i, outs);
            end
            exp_blink = ((ecnt / 2) % 2) == 1;
            vecs++;
            if (bus.blink_clk !== exp_blink) begin
                errs++;
                $display("FAIL blink_idle_%0d: got %b want %b", i, bus.blink_clk, exp_blink);
            end
        end
    endtask

    task automatic test_turn_hold();
        bus.turn_left = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b0100) begin
                errs++;
                $display("FAIL turn_held_%0d: got %b want 0100", i, outs);
            end
        end
        // Released from here: the hold covers this cycle plus two more edges.
        bus.turn_left = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b0100) begin
                errs++;
                $display("FAIL turn_hold_%0d: got %b want 0100", i, outs);
            end
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b0000) begin
                errs++;
                $display("FAIL turn_expired_%0d: got %b want 0000", i, outs);
            end
        end
    endtask

    task automatic test_brake_switch();
        bus.brake = 1'b1;
        bus.turn_left = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b0110) begin
            errs++;
            $display("FAIL brake_turn_l: got %b want 0110", outs);
        end
        bus.turn_left = 1'b0;
        bus.turn_right = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b1001) begin
            errs++;
            $display("FAIL switch_to_r: got %b want 1001", outs);
        end
        bus.turn_left = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b1001) begin
            errs++;
            $display("FAIL both_stalks: got %b want 1001", outs);
        end
        bus.turn_left = 1'b0;
        bus.turn_right = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b1001) begin
                errs++;
                $display("FAIL r_hold_%0d: got %b want 1001", i, outs);
            end
        end
        tick();
        vecs++;
        if (outs !== 4'b0011) begin
            errs++;
            $display("FAIL brake_only: got %b want 0011", outs);
        end
    endtask

    task automatic test_hazard();
        bus.hazard_btn = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b1100) begin
            errs++;
            $display("FAIL hazard_on: got %b want 1100", outs);
        end
        bus.hazard_btn = 1'b0;
        tick();
        bus.hazard_btn = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b0011) begin
            errs++;
            $display("FAIL hazard_off: got %b want 0011", outs);
        end
        bus.hazard_btn = 1'b0;
        tick();
        bus.hazard_btn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b1100) begin
                errs++;
                $display("FAIL hazard_hold_%0d: got %b want 1100", i, outs);
            end
        end
        bus.hazard_btn = 1'b0;
        bus.turn_left = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b1100) begin
            errs++;
            $display("FAIL hazard_masks_turn: got %b want 1100", outs);
        end
        bus.hazard_btn = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b0110) begin
            errs++;
            $display("FAIL turn_tracked: got %b want 0110", outs);
        end
        bus.hazard_btn = 1'b0;
        bus.turn_left = 1'b0;
        bus.brake = 1'b0;
        tick();
    endtask

    task automatic test_power_drop();
        bus.hazard_btn = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b1100) begin
            errs++;
            $display("FAIL pre_drop_hazard: got %b want 1100", outs);
        end
        bus.hazard_btn = 1'b0;
        bus.power_on = 1'b0;
        tick();
        vecs++;
        if (outs !== 4'b0000) begin
            errs++;
            $display("FAIL drop_hazard: got %b want 0000", outs);
        end
        bus.power_on = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b0011) begin
                errs++;
                $display("FAIL st_partial_%0d: got %b want 0011", i, outs);
            end
        end
        bus.power_on = 1'b0;
        tick();
        vecs++;
        if (outs !== 4'b0000) begin
            errs++;
            $display("FAIL drop_selftest: got %b want 0000", outs);
        end
        bus.power_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) bus.hazard_btn = 1'b1;
            if (i == 2) bus.hazard_btn = 1'b0;
            tick();
            vecs++;
            if (outs !== 4'b0011) begin
                errs++;
                $display("FAIL st_full_%0d: got %b want 0011", i, outs);
            end
        end
        tick();
        vecs++;
        if (outs !== 4'b1100) begin
            errs++;
            $display("FAIL st_hazard_latched: got %b want 1100", outs);
        end
        bus.hazard_btn = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b0000) begin
            errs++;
            $display("FAIL hazard_cleared: got %b want 0000", outs);
        end
        bus.hazard_btn = 1'b0;
    endtask

    task automatic test_async_reset();
        bus.turn_right = 1'b1;
        tick();
        vecs++;
        if (outs !== 4'b1000) begin
            errs++;
            $display("FAIL turn_r: got %b want 1000", outs);
        end
        for (int i = 0; i < 4 && ((ecnt / 2) % 2) != 1; i++) tick();
        vecs++;
        if (bus.blink_clk !== 1'b1) begin
            errs++;
            $display("FAIL blink_pre_rst: got %b want 1", bus.blink_clk);
        end
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if (outs !== 4'b0000) begin
            errs++;
            $display("FAIL async_rst_outs: got %b want 0000", outs);
        end
        vecs++;
        if (bus.blink_clk !== 1'b0) begin
            errs++;
            $display("FAIL async_rst_blink: got %b want 0", bus.blink_clk);
        end
        bus.turn_right = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        ecnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            vecs++;
            if (outs !== 4'b0011) begin
                errs++;
                $display("FAIL rst_selftest_%0d: got %b want 0011", i, outs);
            end
        end
        tick();
        vecs++;
        if (outs !== 4'b0000) begin
            errs++;
            $display("FAIL rst_idle: got %b want 0000", outs);
        end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        ecnt = 0;
        exp_blink = 1'b0;
        test_reset();
        test_selftest();
        test_turn_hold();
        test_brake_switch();
        test_hazard();
        test_power_drop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
